// File: rtl/mem_pkg.sv
// Shared constants and encodings for the memory access arbiter.
package mem_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 32;
   localparam logic [31:0] MEM_RAM_BASE   = 32'h1000_0000;

   // FSM encodings kept as plain constants so legacy code can still compare against them
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_RESP   = ST_RESP
   } state_e;

   // Requester IDs; also the bit index of each request in the arbiter vector
   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// requester that was not granted last wins.
module rr_arbiter_2 (
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic [1:0] o_gnt
);

   // One-hot grant selection
   always_comb begin
      o_gnt = '0;
      if (i_req == 2'b11) begin
         o_gnt = i_last_gnt ? 2'b01 : 2'b10;
      end else begin
         o_gnt = i_req;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates a fetch port and a data port onto a single memory interface,
// one transaction at a time (IDLE -> ACCESS -> RESP). Data writes below
// RAM_BASE are rejected with an error response and never reach memory.
module mem_access_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH = MEM_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0]   RAM_BASE   = DATA_WIDTH'(MEM_RAM_BASE)
) (
   input  logic                  clk,
   input  logic                  reset,
   // fetch port
   input  logic                  if_req_i,
   input  logic [DATA_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   // data port
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [DATA_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic                  d_err_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   // memory side
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   state_e                r_state;
   port_e                 r_owner;
   port_e                 r_last_gnt;
   logic                  r_we;
   logic                  r_wr_err;
   logic                  r_mem_we;
   logic [DATA_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic                  r_if_gnt;
   logic                  r_d_gnt;
   logic                  r_if_rvalid;
   logic                  r_d_rvalid;
   logic                  r_d_err;

   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_last_is_d;
   logic                  w_d_wr_legal;

   assign w_req        = {d_req_i, if_req_i};
   assign w_last_is_d  = (r_last_gnt == PORT_D);
   assign w_d_wr_legal = (d_addr_i >= RAM_BASE);

   rr_arbiter_2 u_rr (
      .i_req      (w_req),
      .i_last_gnt (w_last_is_d),
      .o_gnt      (w_gnt)
   );

   // Transaction FSM and datapath. The write strobe is armed at grant so it is
   // high exactly for the ACCESS cycle; rvalid is registered on leaving RESP,
   // so it lands two cycles after gnt and overlaps the next IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_owner     <= PORT_IF;
         r_last_gnt  <= PORT_D;
         r_we        <= 1'b0;
         r_wr_err    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_resp_data <= '0;
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_err     <= 1'b0;
         r_mem_we    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|w_req) begin
                  r_state <= S_ACCESS;
                  if (w_gnt[PORT_D]) begin
                     r_owner     <= PORT_D;
                     r_last_gnt  <= PORT_D;
                     r_d_gnt     <= 1'b1;
                     r_mem_addr  <= d_addr_i;
                     r_mem_wdata <= d_wdata_i;
                     r_we        <= d_we_i;
                     r_wr_err    <= d_we_i && !w_d_wr_legal;
                     r_mem_we    <= d_we_i && w_d_wr_legal;
                  end else begin
                     r_owner     <= PORT_IF;
                     r_last_gnt  <= PORT_IF;
                     r_if_gnt    <= 1'b1;
                     r_mem_addr  <= if_addr_i;
                     r_mem_wdata <= '0;
                     r_we        <= 1'b0;
                     r_wr_err    <= 1'b0;
                  end
               end
            end
            S_ACCESS: begin
               r_resp_data <= r_we ? '0 : mem_rdata_i;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (r_owner == PORT_D) begin
                  r_d_rvalid <= 1'b1;
                  r_d_err    <= r_wr_err;
               end else begin
                  r_if_rvalid <= 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_gnt_o    = r_if_gnt;
   assign if_rvalid_o = r_if_rvalid;
   assign if_rdata_o  = r_resp_data;
   assign d_gnt_o     = r_d_gnt;
   assign d_rvalid_o  = r_d_rvalid;
   assign d_err_o     = r_d_err;
   assign d_rdata_o   = r_resp_data;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus a
// randomized single-transaction stream checked against a transaction-level model.
module tb_mem_access_arbiter;

   localparam int unsigned DW       = 32;
   localparam logic [31:0] RAM_BASE = 32'h1000_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [31:0]   if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [31:0]   d_addr = '0, d_wdata = '0;
   logic          d_gnt, d_rvalid, d_err;
   logic [31:0]   d_rdata;
   logic          mem_we;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.DATA_WIDTH(DW), .RAM_BASE(RAM_BASE)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_err_o(d_err), .d_rdata_o(d_rdata),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Memory environment (driven by the DUT) and the model's view of memory
   logic [31:0] env_mem   [0:63];
   logic [31:0] model_mem [0:63];

   function automatic logic [5:0] midx(input logic [31:0] a);
      return {a[28], a[6:2]};
   endfunction

   assign mem_rdata = env_mem[midx(mem_addr)];
   always @(posedge clk) if (mem_we) env_mem[midx(mem_addr)] <= mem_wdata;

   // Event monitor, sampled on the falling edge
   typedef struct { int cyc; bit port; logic [31:0] data; logic err; } ev_t;
   ev_t         gnt_q[$];
   ev_t         rv_q[$];
   int          we_cnt = 0;
   logic [31:0] we_addr = '0, we_data = '0;

   always @(negedge clk) begin
      if (if_gnt)    gnt_q.push_back(ev_t'{cyc, 1'b0, 32'h0, 1'b0});
      if (d_gnt)     gnt_q.push_back(ev_t'{cyc, 1'b1, 32'h0, 1'b0});
      if (if_rvalid) rv_q.push_back(ev_t'{cyc, 1'b0, if_rdata, 1'b0});
      if (d_rvalid)  rv_q.push_back(ev_t'{cyc, 1'b1, d_rdata, d_err});
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_wdata;
      end
   end

   // Transaction-level reference: what a request should return by the rules
   function automatic void model_txn(input bit port, input bit we, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic [31:0] rdata,
                                     output logic err, output int wes);
      rdata = '0; err = 1'b0; wes = 0;
      if (port && we) begin
         if (addr < RAM_BASE) err = 1'b1;
         else begin
            model_mem[midx(addr)] = wdata;
            wes = 1;
         end
      end else begin
         rdata = model_mem[midx(addr)];
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives one request on one port and observes the handshake (no checking)
   task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int glat, output int rlat,
                          output logic [31:0] rdata, output logic err, output int wes,
                          output int other);
      int t0, tg, w0, n;
      glat = -1; rlat = -1; rdata = '0; err = 1'b0; wes = 0; other = 0;
      w0 = we_cnt;
      @(negedge clk);
      if (port) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
      else begin if_req = 1'b1; if_addr = addr; end
      t0 = cyc; n = 0;
      while (glat < 0 && n < 20) begin
         @(negedge clk); n++;
         if (port ? if_gnt : d_gnt) other++;
         if (port ? d_gnt : if_gnt) glat = cyc - t0;
      end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if (glat < 0) return;
      tg = cyc; n = 0;
      while (rlat < 0 && n < 20) begin
         @(negedge clk); n++;
         if (port ? if_rvalid : d_rvalid) other++;
         if (port ? d_rvalid : if_rvalid) begin
            rlat  = cyc - tg;
            rdata = port ? d_rdata : if_rdata;
            err   = d_err;
         end
      end
      wes = we_cnt - w0;
   endtask

   task automatic test_reset();
      logic [5:0] flags;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         flags = {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_we};
         n_tests++;
         if (flags !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags[%0d]: got %b expected 000000", k, flags);
         end
         n_tests++;
         if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_regs[%0d]: addr %h wdata %h rdata %h/%h expected 0",
                               k, mem_addr, mem_wdata, if_rdata, d_rdata);
         end
         if (k == 0) begin
            @(negedge clk); reset = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_contention();
      int m;
      logic [31:0] exp;
      reset = 1'b1;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0020;
      repeat (2) @(negedge clk);
      gnt_q.delete(); rv_q.delete();
      reset = 1'b0;
      repeat (13) @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (gnt_q.size() != 5) begin
         n_fail++; $display("FAIL contention_gnt_count: got %0d expected 5", gnt_q.size());
      end
      n_tests++;
      if (rv_q.size() != gnt_q.size()) begin
         n_fail++; $display("FAIL contention_rv_count: got %0d expected %0d", rv_q.size(), gnt_q.size());
      end
      m = (rv_q.size() < gnt_q.size()) ? rv_q.size() : gnt_q.size();
      for (int i = 0; i < gnt_q.size(); i++) begin
         n_tests++;
         if (gnt_q[i].port !== 1'(i % 2)) begin
            n_fail++; $display("FAIL contention_order[%0d]: got port %0d expected %0d", i, gnt_q[i].port, i % 2);
         end
         if (i > 0) begin
            n_tests++;
            if (gnt_q[i].cyc - gnt_q[i-1].cyc != 3) begin
               n_fail++; $display("FAIL contention_spacing[%0d]: got %0d expected 3", i, gnt_q[i].cyc - gnt_q[i-1].cyc);
            end
         end
      end
      for (int i = 0; i < m; i++) begin
         exp = gnt_q[i].port ? model_mem[midx(32'h1000_0020)] : model_mem[midx(32'h10)];
         n_tests++;
         if (rv_q[i].port !== gnt_q[i].port || rv_q[i].cyc != gnt_q[i].cyc + 2 || rv_q[i].data !== exp) begin
            n_fail++; $display("FAIL contention_resp[%0d]: got port %0d lat %0d data %h expected port %0d lat 2 data %h",
                               i, rv_q[i].port, rv_q[i].cyc - gnt_q[i].cyc, rv_q[i].data, gnt_q[i].port, exp);
         end
      end
   endtask

   task automatic test_fetch_rom();
      int glat, rlat, wes, other;
      logic [31:0] rd;
      logic er;
      run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, glat, rlat, rd, er, wes, other);
      n_tests++;
      if (glat != 1 || rlat != 2) begin
         n_fail++; $display("FAIL fetch_latency: got gnt %0d rvalid %0d expected 1 and 2", glat, rlat);
      end
      n_tests++;
      if (rd !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL fetch_rdata: got %h expected deadbeef", rd);
      end
      n_tests++;
      if (other != 0 || wes != 0 || er !== 1'b0) begin
         n_fail++; $display("FAIL fetch_side_effects: got other %0d writes %0d err %b expected 0 0 0", other, wes, er);
      end
      @(negedge clk);
      n_tests++;
      if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: got addr %h we %b expected 00000010 0", mem_addr, mem_we);
      end
   endtask

   task automatic test_ram_write_read();
      int glat, rlat, wes, other, ewes;
      logic [31:0] rd, erd;
      logic er, eer;
      run_txn(1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678, glat, rlat, rd, er, wes, other);
      model_txn(1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678, erd, eer, ewes);
      n_tests++;
      if (wes != 1 || er !== 1'b0 || rd !== 32'h0 || glat != 1 || rlat != 2) begin
         n_fail++; $display("FAIL ram_write: got writes %0d err %b rdata %h lat %0d/%0d expected 1 0 0 1/2",
                            wes, er, rd, glat, rlat);
      end
      n_tests++;
      if (we_addr !== 32'h1000_0004 || we_data !== 32'h1234_5678) begin
         n_fail++; $display("FAIL ram_write_bus: got %h<-%h expected 10000004<-12345678", we_addr, we_data);
      end
      run_txn(1'b1, 1'b0, 32'h1000_0004, 32'h0, glat, rlat, rd, er, wes, other);
      n_tests++;
      if (rd !== 32'h1234_5678 || er !== 1'b0 || wes != 0) begin
         n_fail++; $display("FAIL ram_readback: got %h err %b writes %0d expected 12345678 0 0", rd, er, wes);
      end
   endtask

   task automatic test_rom_write();
      logic [31:0] ta [6];
      logic        tw [6];
      int glat, rlat, wes, other, ewes;
      logic [31:0] rd, erd, wd;
      logic er, eer;
      ta = '{32'h0000_0008, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0000, 32'h0000_0008, 32'h0FFF_FFFC};
      tw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         wd = $urandom;
         run_txn(1'b1, tw[i], ta[i], wd, glat, rlat, rd, er, wes, other);
         model_txn(1'b1, tw[i], ta[i], wd, erd, eer, ewes);
         n_tests++;
         if (rd !== erd || er !== eer || wes != ewes || glat != 1 || rlat != 2 || other != 0) begin
            n_fail++; $display("FAIL boundary[%0d] %h we=%b: got rdata %h err %b writes %0d lat %0d/%0d expected %h %b %0d 1/2",
                               i, ta[i], tw[i], rd, er, wes, glat, rlat, erd, eer, ewes);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      gnt_q.delete(); rv_q.delete();
      if_req = 1'b1; if_addr = 32'h20;
      repeat (10) @(negedge clk);
      if_req = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (gnt_q.size() != 4 || rv_q.size() != 4) begin
         n_fail++; $display("FAIL held_req_count: got %0d gnts %0d rvalids expected 4 4", gnt_q.size(), rv_q.size());
      end
      for (int i = 1; i < gnt_q.size(); i++) begin
         n_tests++;
         if (gnt_q[i].cyc - gnt_q[i-1].cyc != 3 || gnt_q[i].port !== 1'b0) begin
            n_fail++; $display("FAIL held_req_spacing[%0d]: got %0d port %0d expected 3 port 0",
                               i, gnt_q[i].cyc - gnt_q[i-1].cyc, gnt_q[i].port);
         end
      end
   endtask

   task automatic test_drop();
      int n, nf, nd;
      @(negedge clk);
      gnt_q.delete(); rv_q.delete();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0010;
      n = 0;
      while (!d_gnt && n < 20) begin @(negedge clk); n++; end
      d_req = 1'b0;
      if_req = 1'b1; if_addr = 32'h30;
      @(negedge clk);
      if_req = 1'b0;
      repeat (6) @(negedge clk);
      nf = 0; nd = 0;
      foreach (gnt_q[i]) if (gnt_q[i].port == 1'b0) nf++;
      foreach (rv_q[i])  if (rv_q[i].port == 1'b1) nd++;
      n_tests++;
      if (nf != 0 || nd != 1) begin
         n_fail++; $display("FAIL dropped_req: got %0d fetch gnts %0d data rvalids expected 0 1", nf, nd);
      end
   endtask

   task automatic test_reset_mid();
      int n, glat, rlat, wes, other;
      logic [31:0] rd, wd;
      logic er;
      logic [7:0] flags;
      wd = $urandom;
      @(negedge clk);
      gnt_q.delete(); rv_q.delete();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0044; d_wdata = wd;
      n = 0;
      while (!d_gnt && n < 20) begin @(negedge clk); n++; end
      d_req = 1'b0; d_we = 1'b0;
      #2 reset = 1'b1;
      #1;
      flags = {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_we, |mem_addr, |mem_wdata};
      n_tests++;
      if (flags !== 8'b0) begin
         n_fail++; $display("FAIL async_reset_outputs: got %b expected 00000000", flags);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (rv_q.size() != 0) begin
         n_fail++; $display("FAIL aborted_rvalid: got %0d responses expected 0", rv_q.size());
      end
      run_txn(1'b1, 1'b0, 32'h1000_0044, 32'h0, glat, rlat, rd, er, wes, other);
      n_tests++;
      if (rd !== model_mem[midx(32'h1000_0044)]) begin
         n_fail++; $display("FAIL aborted_write_mem: got %h expected %h", rd, model_mem[midx(32'h1000_0044)]);
      end
      // leave last_gnt at fetch, then reset: contention must still go to fetch
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, glat, rlat, rd, er, wes, other);
      do_reset();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0000;
      n = 0;
      while (!if_gnt && !d_gnt && n < 20) begin @(negedge clk); n++; end
      n_tests++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_first_winner: got if_gnt %b d_gnt %b expected 1 0", if_gnt, d_gnt);
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random();
      int glat, rlat, wes, other, ewes;
      logic [31:0] rd, erd, addr, wd;
      logic er, eer;
      bit port, we;
      for (int i = 0; i < 40; i++) begin
         port = 1'($urandom_range(0, 1));
         we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
         case ($urandom_range(0, 3))
            0: addr = 32'($urandom_range(0, 31)) << 2;
            1: addr = RAM_BASE + (32'($urandom_range(0, 31)) << 2);
            2: addr = 32'h0FFF_FFFC;
            default: addr = RAM_BASE;
         endcase
         wd = $urandom;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_txn(port, we, addr, wd, glat, rlat, rd, er, wes, other);
         model_txn(port, we, addr, wd, erd, eer, ewes);
         n_tests++;
         if (rd !== erd || er !== eer || wes != ewes || glat != 1 || rlat != 2 || other != 0) begin
            n_fail++; $display("FAIL random[%0d] port %0d we %0d addr %h: got rdata %h err %b writes %0d lat %0d/%0d other %0d expected %h %b %0d 1/2 0",
                               i, port, we, addr, rd, er, wes, glat, rlat, other, erd, eer, ewes);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         env_mem[i]   = 32'hC0DE_0000 + 32'(i) * 32'h0001_0011;
         model_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_0011;
      end
      env_mem[4]   = 32'hDEAD_BEEF;
      model_mem[4] = 32'hDEAD_BEEF;
      #1 reset = 1'b1;
      test_reset();
      test_contention();
      test_fetch_rom();
      test_ram_write_read();
      test_rom_write();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
